// File: rtl/axis_pkt_arbiter_pkg.sv
// Shared types and constants for the packet-granular AXIS arbiter.
package axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam int AXIS_DATA_W = 8;
  localparam int AXIS_BEAT_W = AXIS_DATA_W + 1;

endpackage

// File: rtl/axis_pkt_arbiter_if.sv
// Bundle of the per-source AXIS inputs, the FIFO-side AXIS output and arbiter status.
// Handshake: a beat moves on a rising edge where valid and ready are both high; valid
// must not depend on ready, and data/last hold while valid is high and ready is low.
interface axis_pkt_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ*DATA_W-1:0] s_axis_data;
  logic [NUM_REQ-1:0]        s_axis_valid;
  logic [NUM_REQ-1:0]        s_axis_last;
  logic [NUM_REQ-1:0]        s_axis_ready;
  logic [DATA_W-1:0]         m_axis_data;
  logic                      m_axis_valid;
  logic                      m_axis_last;
  logic                      m_axis_ready;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;

  // slave: the arbiter itself; master: the sources plus the FIFO sink around it
  modport slave (
    input  s_axis_data, s_axis_valid, s_axis_last, m_axis_ready,
    output s_axis_ready, m_axis_data, m_axis_valid, m_axis_last, grant_id, busy
  );

  modport master (
    output s_axis_data, s_axis_valid, s_axis_last, m_axis_ready,
    input  s_axis_ready, m_axis_data, m_axis_valid, m_axis_last, grant_id, busy
  );

endinterface

// File: rtl/axis_pkt_arbiter_rr_pick.sv
// Rotating-priority encoder: first requester after i_last_gnt, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_last_gnt,
  output logic [ID_W-1:0]    o_gnt_id,
  output logic               o_gnt_vld
);

  always_comb begin
    o_gnt_id  = '0;
    o_gnt_vld = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!o_gnt_vld && i_req[(int'(i_last_gnt) + k) % NUM_REQ]) begin
        o_gnt_id  = ID_W'((int'(i_last_gnt) + k) % NUM_REQ);
        o_gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin arbiter feeding one AXIS FIFO write port through a register.
// Optional per-source completed-packet counters: define AXIS_ARB_PKT_CNT_EN.
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
`ifdef AXIS_ARB_PKT_CNT_EN
  ,
  parameter int CNT_W   = 16
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  axis_pkt_arbiter_if.slave        bus
`ifdef AXIS_ARB_PKT_CNT_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0] pkt_cnt
`endif
);

  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BEAT_W = AXIS_BEAT_W - AXIS_DATA_W + DATA_W;

  arb_state_t         r_state;
  logic [ID_W-1:0]    r_grant;
  logic [ID_W-1:0]    r_last_gnt;
  logic [BEAT_W-1:0]  r_beat;
  logic               r_m_valid;

  logic [ID_W-1:0]    w_pick_id;
  logic               w_pick_vld;
  logic               w_out_free;
  logic               w_accept;
  logic               w_src_last;
  logic [DATA_W-1:0]  w_src_data;
  logic [NUM_REQ-1:0] w_ready;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .i_req      (bus.s_axis_valid),
    .i_last_gnt (r_last_gnt),
    .o_gnt_id   (w_pick_id),
    .o_gnt_vld  (w_pick_vld)
  );

  assign w_out_free = ~r_m_valid | bus.m_axis_ready;
  assign w_src_data = bus.s_axis_data[r_grant*DATA_W +: DATA_W];
  assign w_src_last = bus.s_axis_last[r_grant];
  assign w_accept   = (r_state == LOCK) & w_out_free & bus.s_axis_valid[r_grant];

  always_comb begin
    w_ready = '0;
    if (r_state == LOCK && w_out_free) w_ready[r_grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_last_gnt <= ID_W'(NUM_REQ - 1);
    end else begin
      case (r_state)
        IDLE: if (w_pick_vld) begin
          r_grant <= w_pick_id;
          r_state <= LOCK;
        end
        LOCK: if (w_accept && w_src_last) begin
          r_last_gnt <= r_grant;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output stage holds its beat while the FIFO stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat    <= '0;
      r_m_valid <= 1'b0;
    end else if (w_accept) begin
      r_beat    <= {w_src_last, w_src_data};
      r_m_valid <= 1'b1;
    end else if (bus.m_axis_ready) begin
      r_m_valid <= 1'b0;
    end
  end

`ifdef AXIS_ARB_PKT_CNT_EN
  logic [NUM_REQ*CNT_W-1:0] r_pkt_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt <= '0;
    end else if (w_accept && w_src_last) begin
      r_pkt_cnt[r_grant*CNT_W +: CNT_W] <= r_pkt_cnt[r_grant*CNT_W +: CNT_W] + CNT_W'(1);
    end
  end

  assign pkt_cnt = r_pkt_cnt;
`endif

  assign bus.s_axis_ready = w_ready;
  assign bus.m_axis_data  = r_beat[DATA_W-1:0];
  assign bus.m_axis_last  = r_beat[DATA_W];
  assign bus.m_axis_valid = r_m_valid;
  assign bus.grant_id     = r_grant;
  assign bus.busy         = (r_state == LOCK);

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed bench for axis_pkt_arbiter: scripted sources, FIFO sink and expected-beat queues.
module tb_axis_pkt_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 16;
  localparam int ID_W    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_pkt_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

`ifdef AXIS_ARB_PKT_CNT_EN
  logic [NUM_REQ*CNT_W-1:0] pkt_cnt;
`endif

  axis_pkt_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W)
`ifdef AXIS_ARB_PKT_CNT_EN
    ,
    .CNT_W   (CNT_W)
`endif
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave)
`ifdef AXIS_ARB_PKT_CNT_EN
    ,
    .pkt_cnt (pkt_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // source model: per-source beat script {last, data}
  logic [8:0]         mem [NUM_REQ][16];
  int                 len [NUM_REQ];
  int                 ptr [NUM_REQ];
  logic [NUM_REQ-1:0] en;

  // observation and expectation
  logic [8:0]      obs_q[$];
  int              obs_cyc_q[$];
  logic [ID_W-1:0] gnt_q[$];
  logic [8:0]      exp_q[$];
  int              exp_cyc_q[$];
  logic [ID_W-1:0] exp_gnt_q[$];
  int              cyc;
  bit              prev_busy;
  int              multi_rdy;
  int              bad_rdy;

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (en[i] && ptr[i] < len[i]) begin
        bus.s_axis_valid[i]                  = 1'b1;
        bus.s_axis_data[i*DATA_W +: DATA_W]  = mem[i][ptr[i]][7:0];
        bus.s_axis_last[i]                   = mem[i][ptr[i]][8];
      end else begin
        bus.s_axis_valid[i]                  = 1'b0;
        bus.s_axis_data[i*DATA_W +: DATA_W]  = '0;
        bus.s_axis_last[i]                   = 1'b0;
      end
    end
  endtask

  task automatic clear_all();
    obs_q.delete(); obs_cyc_q.delete(); gnt_q.delete();
    exp_q.delete(); exp_cyc_q.delete(); exp_gnt_q.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      len[i] = 0;
      ptr[i] = 0;
    end
    en = '0;
    cyc = 0;
    prev_busy = 1'b0;
    multi_rdy = 0;
    bad_rdy = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.m_axis_ready = 1'b1;
    clear_all();
    drive();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic add_pkt(input int src, input int nbeats, input logic [7:0] base);
    for (int b = 0; b < nbeats; b++) begin
      mem[src][len[src]] = {(b == nbeats - 1) ? 1'b1 : 1'b0, 8'(base + b)};
      len[src]++;
    end
  endtask

  task automatic exp_pkt(input int nbeats, input logic [7:0] base, input int c0);
    for (int b = 0; b < nbeats; b++) begin
      exp_q.push_back({(b == nbeats - 1) ? 1'b1 : 1'b0, 8'(base + b)});
      exp_cyc_q.push_back(c0 + b);
    end
  endtask

  // one clock: sample at negedge, advance sources just after the rising edge
  task automatic step();
    logic [NUM_REQ-1:0] acc;
    logic [NUM_REQ-1:0] oh;
    @(negedge clk);
    if (bus.m_axis_valid && bus.m_axis_ready) begin
      obs_q.push_back({bus.m_axis_last, bus.m_axis_data});
      obs_cyc_q.push_back(cyc);
    end
    acc = bus.s_axis_ready & bus.s_axis_valid;
    oh  = NUM_REQ'(1) << bus.grant_id;
    if ($countones(bus.s_axis_ready) > 1) multi_rdy++;
    if ((bus.s_axis_ready & ~oh) != '0) bad_rdy++;
    if (bus.busy && !prev_busy) gnt_q.push_back(bus.grant_id);
    prev_busy = bus.busy;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NUM_REQ; i++) if (acc[i]) ptr[i]++;
    drive();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (bus.m_axis_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid got %b want 0", bus.m_axis_valid); end
    n_checks++; if (bus.m_axis_data !== 8'h00) begin n_fail++; $display("FAIL rst_m_data got %h want 00", bus.m_axis_data); end
    n_checks++; if (bus.m_axis_last !== 1'b0) begin n_fail++; $display("FAIL rst_m_last got %b want 0", bus.m_axis_last); end
    n_checks++; if (bus.s_axis_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_s_ready got %b want 0000", bus.s_axis_ready); end
    n_checks++; if (bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_grant_id got %0d want 0", bus.grant_id); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", bus.busy); end
`ifdef AXIS_ARB_PKT_CNT_EN
    n_checks++; if (pkt_cnt !== '0) begin n_fail++; $display("FAIL rst_pkt_cnt got %h want 0", pkt_cnt); end
`endif
  endtask

  task automatic test_single_source();
    apply_reset();
    add_pkt(0, 3, 8'h11);
    en = 4'b0001;
    drive();
    exp_pkt(3, 8'h11, 2);
    for (int t = 0; t < 20 && obs_q.size() < 3; t++) step();
    n_checks++; if (obs_q.size() !== 3) begin n_fail++; $display("FAIL single_count got %0d want 3", obs_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      n_checks++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k] || obs_cyc_q[k] !== exp_cyc_q[k]) begin
        n_fail++;
        $display("FAIL single_beat%0d got %h@%0d want %h@%0d", k, obs_q[k], obs_cyc_q[k], exp_q[k], exp_cyc_q[k]);
      end
    end
    n_checks++; if (bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL single_grant got %0d want 0", bus.grant_id); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    add_pkt(0, 2, 8'h01);
    add_pkt(0, 2, 8'h09);
    add_pkt(1, 2, 8'h11);
    add_pkt(2, 2, 8'h21);
    add_pkt(3, 2, 8'h31);
    en = 4'b1111;
    drive();
    exp_pkt(2, 8'h01, 2);
    exp_pkt(2, 8'h11, 5);
    exp_pkt(2, 8'h21, 8);
    exp_pkt(2, 8'h31, 11);
    exp_pkt(2, 8'h09, 14);
    exp_gnt_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int t = 0; t < 40 && obs_q.size() < 10; t++) step();
    n_checks++; if (obs_q.size() !== 10) begin n_fail++; $display("FAIL rr_count got %0d want 10", obs_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      n_checks++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k] || obs_cyc_q[k] !== exp_cyc_q[k]) begin
        n_fail++;
        $display("FAIL rr_beat%0d got %h@%0d want %h@%0d", k, obs_q[k], obs_cyc_q[k], exp_q[k], exp_cyc_q[k]);
      end
    end
    for (int k = 0; k < exp_gnt_q.size(); k++) begin
      n_checks++;
      if (k >= gnt_q.size() || gnt_q[k] !== exp_gnt_q[k]) begin
        n_fail++;
        $display("FAIL rr_grant%0d got %0d want %0d", k, gnt_q[k], exp_gnt_q[k]);
      end
    end
    n_checks++; if (multi_rdy !== 0) begin n_fail++; $display("FAIL rr_multi_ready got %0d want 0", multi_rdy); end
    n_checks++; if (bad_rdy !== 0) begin n_fail++; $display("FAIL rr_ungranted_ready got %0d want 0", bad_rdy); end
  endtask

  task automatic test_stall();
    apply_reset();
    add_pkt(1, 4, 8'h31);
    en = 4'b0010;
    drive();
    for (int t = 0; t < 20 && obs_q.size() < 1; t++) step();
    bus.m_axis_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      step();
      n_checks++;
      if (bus.m_axis_valid !== 1'b1 || bus.m_axis_data !== 8'h32 || bus.m_axis_last !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold%0d got v%b %h l%b want v1 32 l0", s, bus.m_axis_valid, bus.m_axis_data, bus.m_axis_last);
      end
      n_checks++;
      if (bus.s_axis_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready%0d got %b want 0000", s, bus.s_axis_ready); end
    end
    bus.m_axis_ready = 1'b1;
    for (int t = 0; t < 20 && obs_q.size() < 4; t++) step();
    exp_q = '{9'h031, 9'h032, 9'h033, 9'h134};
    exp_cyc_q = '{2, 8, 9, 10};
    n_checks++; if (obs_q.size() !== 4) begin n_fail++; $display("FAIL stall_count got %0d want 4", obs_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      n_checks++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k] || obs_cyc_q[k] !== exp_cyc_q[k]) begin
        n_fail++;
        $display("FAIL stall_beat%0d got %h@%0d want %h@%0d", k, obs_q[k], obs_cyc_q[k], exp_q[k], exp_cyc_q[k]);
      end
    end
  endtask

  task automatic test_lock_hold();
    apply_reset();
    add_pkt(2, 4, 8'hA1);
    en = 4'b0100;
    drive();
    step();
    add_pkt(1, 2, 8'hB1);
    en = 4'b0110;
    drive();
    step();
    en[2] = 1'b0;
    drive();
    for (int s = 0; s < 6; s++) begin
      step();
      n_checks++;
      if (bus.grant_id !== 2'd2 || bus.busy !== 1'b1 || bus.s_axis_ready[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL lock_hold%0d got g%0d busy%b rdy%b want g2 busy1 rdy[1]=0", s, bus.grant_id, bus.busy, bus.s_axis_ready);
      end
    end
    en[2] = 1'b1;
    drive();
    for (int t = 0; t < 40 && obs_q.size() < 6; t++) step();
    exp_q = '{9'h0A1, 9'h0A2, 9'h0A3, 9'h1A4, 9'h0B1, 9'h1B2};
    exp_gnt_q = '{2'd2, 2'd1};
    n_checks++; if (obs_q.size() !== 6) begin n_fail++; $display("FAIL lock_count got %0d want 6", obs_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      n_checks++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL lock_beat%0d got %h want %h", k, obs_q[k], exp_q[k]);
      end
    end
    for (int k = 0; k < exp_gnt_q.size(); k++) begin
      n_checks++;
      if (k >= gnt_q.size() || gnt_q[k] !== exp_gnt_q[k]) begin
        n_fail++;
        $display("FAIL lock_grant%0d got %0d want %0d", k, gnt_q[k], exp_gnt_q[k]);
      end
    end
    n_checks++; if (bad_rdy !== 0) begin n_fail++; $display("FAIL lock_ungranted_ready got %0d want 0", bad_rdy); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    add_pkt(3, 4, 8'h41);
    en = 4'b1000;
    drive();
    for (int t = 0; t < 20 && obs_q.size() < 2; t++) step();
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.m_axis_valid !== 1'b0 || bus.m_axis_data !== 8'h00 || bus.m_axis_last !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_out got v%b %h l%b want v0 00 l0", bus.m_axis_valid, bus.m_axis_data, bus.m_axis_last);
    end
    n_checks++;
    if (bus.s_axis_ready !== 4'b0000 || bus.busy !== 1'b0 || bus.grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL arst_ctl got rdy%b busy%b g%0d want 0000 0 0", bus.s_axis_ready, bus.busy, bus.grant_id);
    end
    clear_all();
    drive();
    @(posedge clk);
    #1 rst_n = 1'b1;
    add_pkt(0, 2, 8'h51);
    add_pkt(3, 2, 8'h61);
    en = 4'b1001;
    drive();
    exp_pkt(2, 8'h51, 2);
    exp_pkt(2, 8'h61, 5);
    exp_gnt_q = '{2'd0, 2'd3};
    for (int t = 0; t < 30 && obs_q.size() < 4; t++) step();
    n_checks++; if (obs_q.size() !== 4) begin n_fail++; $display("FAIL arst_count got %0d want 4", obs_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      n_checks++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k] || obs_cyc_q[k] !== exp_cyc_q[k]) begin
        n_fail++;
        $display("FAIL arst_beat%0d got %h@%0d want %h@%0d", k, obs_q[k], obs_cyc_q[k], exp_q[k], exp_cyc_q[k]);
      end
    end
    for (int k = 0; k < exp_gnt_q.size(); k++) begin
      n_checks++;
      if (k >= gnt_q.size() || gnt_q[k] !== exp_gnt_q[k]) begin
        n_fail++;
        $display("FAIL arst_grant%0d got %0d want %0d", k, gnt_q[k], exp_gnt_q[k]);
      end
    end
  endtask

  task automatic test_single_beat();
    apply_reset();
    add_pkt(1, 1, 8'h71);
    add_pkt(1, 1, 8'h72);
    add_pkt(1, 1, 8'h73);
    add_pkt(3, 2, 8'h81);
    en = 4'b1010;
    drive();
    exp_pkt(1, 8'h71, 2);
    exp_pkt(2, 8'h81, 4);
    exp_pkt(1, 8'h72, 7);
    exp_pkt(1, 8'h73, 9);
    exp_gnt_q = '{2'd1, 2'd3, 2'd1, 2'd1};
    for (int t = 0; t < 30 && obs_q.size() < 5; t++) step();
    repeat (2) step();
    n_checks++; if (obs_q.size() !== 5) begin n_fail++; $display("FAIL sb_count got %0d want 5", obs_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      n_checks++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k] || obs_cyc_q[k] !== exp_cyc_q[k]) begin
        n_fail++;
        $display("FAIL sb_beat%0d got %h@%0d want %h@%0d", k, obs_q[k], obs_cyc_q[k], exp_q[k], exp_cyc_q[k]);
      end
    end
    for (int k = 0; k < exp_gnt_q.size(); k++) begin
      n_checks++;
      if (k >= gnt_q.size() || gnt_q[k] !== exp_gnt_q[k]) begin
        n_fail++;
        $display("FAIL sb_grant%0d got %0d want %0d", k, gnt_q[k], exp_gnt_q[k]);
      end
    end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL sb_idle_busy got %b want 0", bus.busy); end
`ifdef AXIS_ARB_PKT_CNT_EN
    n_checks++; if (pkt_cnt[0*CNT_W +: CNT_W] !== 16'd0) begin n_fail++; $display("FAIL cnt0 got %0d want 0", pkt_cnt[0*CNT_W +: CNT_W]); end
    n_checks++; if (pkt_cnt[1*CNT_W +: CNT_W] !== 16'd3) begin n_fail++; $display("FAIL cnt1 got %0d want 3", pkt_cnt[1*CNT_W +: CNT_W]); end
    n_checks++; if (pkt_cnt[2*CNT_W +: CNT_W] !== 16'd0) begin n_fail++; $display("FAIL cnt2 got %0d want 0", pkt_cnt[2*CNT_W +: CNT_W]); end
    n_checks++; if (pkt_cnt[3*CNT_W +: CNT_W] !== 16'd1) begin n_fail++; $display("FAIL cnt3 got %0d want 1", pkt_cnt[3*CNT_W +: CNT_W]); end
`endif
  endtask

  initial begin
    bus.s_axis_data  = '0;
    bus.s_axis_valid = '0;
    bus.s_axis_last  = '0;
    bus.m_axis_ready = 1'b1;
    test_reset();
    test_single_source();
    test_round_robin();
    test_stall();
    test_lock_hold();
    test_async_reset();
    test_single_beat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
